// File: rtl/sauria_addr_pkg.sv
// SAURIA address map: region table, region index type and router ID tag.
package sauria_addr_pkg;

  localparam int NUM_REGIONS = 8;

  typedef logic [$clog2(NUM_REGIONS)-1:0] region_idx_t;

  // Region order: REGS, CON, ACT, WEI, OUT, SRAMA, SRAMB, SRAMC.
  localparam logic [31:0] DEF_REGION_BASE [NUM_REGIONS] = '{
    32'h0000_0000, 32'h0000_0200, 32'h0000_0400, 32'h0000_0600,
    32'h0000_0800, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000
  };

  localparam logic [31:0] DEF_REGION_MASK [NUM_REGIONS] = '{
    32'h000F_FE00, 32'h000F_FE00, 32'h000F_FE00, 32'h000F_FE00,
    32'h000F_FE00, 32'h000F_0000, 32'h000F_0000, 32'h000F_0000
  };

  typedef struct packed {
    logic        miss;
    region_idx_t idx;
  } tgt_id_t;

endpackage

// File: rtl/sauria_id_fifo.sv
// Synchronous FIFO holding the ordering tags of outstanding transactions.
module sauria_id_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Storage: written at the tail on push, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= PW'(r_wptr + 1'b1);
      if (w_pop)  r_rptr <= PW'(r_rptr + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= CW'(r_count + 1'b1);
        2'b01:   r_count <= CW'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sauria_addr_router.sv
// Decodes host requests onto NUM_TGT regions and returns responses in order.
module sauria_addr_router
  import sauria_addr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_TGT = NUM_REGIONS,
  parameter int MAX_OUT = 4,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_TGT] = DEF_REGION_BASE,
  parameter logic [ADDR_W-1:0] REGION_MASK [NUM_TGT] = DEF_REGION_MASK
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_W-1:0]            i_req_addr,
  input  logic                         i_req_we,
  input  logic [DATA_W-1:0]            i_req_wdata,
  input  logic [DATA_W/8-1:0]          i_req_be,
  output logic [NUM_TGT-1:0]           o_tgt_valid,
  input  logic [NUM_TGT-1:0]           i_tgt_ready,
  output logic [ADDR_W-1:0]            o_tgt_addr,
  output logic                         o_tgt_we,
  output logic [DATA_W-1:0]            o_tgt_wdata,
  output logic [DATA_W/8-1:0]          o_tgt_be,
  input  logic [NUM_TGT-1:0]           i_tgt_rvalid,
  input  logic [NUM_TGT*DATA_W-1:0]    i_tgt_rdata,
  output logic                         o_rsp_valid,
  output logic [DATA_W-1:0]            o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic                         o_proto_err,
  output logic [$clog2(MAX_OUT+1)-1:0] o_outstanding
);
  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  // Tag kept per outstanding transaction; we forces read data to zero.
  typedef struct packed {
    logic             we;
    logic             miss;
    logic [IDX_W-1:0] idx;
  } ent_t;

  logic [NUM_TGT-1:0]             w_hit, w_expect;
  logic [IDX_W-1:0]               w_sel;
  logic                           w_miss, w_full, w_empty, w_fwd, w_ready, w_push, w_pop;
  ent_t                           w_push_ent, w_head;
  logic [$bits(ent_t)-1:0]        w_head_bits;
  logic [NUM_TGT-1:0][DATA_W-1:0] w_rdata;
  logic                           r_rsp_valid, r_rsp_err, r_proto_err;
  logic [DATA_W-1:0]              r_rsp_rdata;

  assign w_rdata = i_tgt_rdata;
  assign w_head  = w_head_bits;

  // Per-target region match, valid steering and expected-response mask.
  for (genvar g = 0; g < NUM_TGT; g++) begin : g_tgt
    assign w_hit[g]       = ((i_req_addr & REGION_MASK[g]) == REGION_BASE[g]);
    assign o_tgt_valid[g] = w_fwd & (w_sel == IDX_W'(g));
    assign w_expect[g]    = ~w_empty & ~w_head.miss & (w_head.idx == IDX_W'(g));
  end

  // Priority select: lowest-index matching region wins.
  always_comb begin
    w_sel  = '0;
    w_miss = 1'b1;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel  = IDX_W'(i);
        w_miss = 1'b0;
      end
    end
  end

  // Misses are never forwarded; they only occupy an ordering slot.
  assign w_fwd       = ~i_rst & i_req_valid & ~w_full & ~w_miss;
  assign w_ready     = ~i_rst & ~w_full & (w_miss | i_tgt_ready[w_sel]);
  assign o_req_ready = w_ready;
  assign w_push      = i_req_valid & w_ready;
  assign w_push_ent  = '{we: i_req_we, miss: w_miss, idx: w_sel};

  assign o_tgt_addr  = i_req_addr & ~REGION_MASK[w_sel];
  assign o_tgt_we    = i_req_we;
  assign o_tgt_wdata = i_req_wdata;
  assign o_tgt_be    = i_req_be;

  // Head retires on its target's rvalid, or unconditionally if it is a miss.
  assign w_pop = ~w_empty & (w_head.miss | i_tgt_rvalid[w_head.idx]);

  sauria_id_fifo #(
    .WIDTH ($bits(ent_t)),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_outstanding)
  );

  // Registered response plus sticky flag for any unexpected rvalid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop;
      r_rsp_err   <= w_pop & w_head.miss;
      r_rsp_rdata <= (w_pop && !w_head.miss && !w_head.we) ? w_rdata[w_head.idx] : '0;
      if (|(i_tgt_rvalid & ~w_expect)) r_proto_err <= 1'b1;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_sauria_addr_router.sv
// Bench for sauria_addr_router: queue-based reference model plus directed cases.
module tb_sauria_addr_router;
  localparam int NT = 8;
  localparam int MO = 4;

  localparam logic [31:0] BASE [NT] = '{32'h0000_0000, 32'h0000_0200, 32'h0000_0400,
    32'h0000_0600, 32'h0000_0800, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
  localparam logic [31:0] MASK [NT] = '{32'h000F_FE00, 32'h000F_FE00, 32'h000F_FE00,
    32'h000F_FE00, 32'h000F_FE00, 32'h000F_0000, 32'h000F_0000, 32'h000F_0000};

  logic          clk = 1'b0, rst = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata, tgt_addr, tgt_wdata, rsp_rdata;
  logic [3:0]    req_be, tgt_be;
  logic [NT-1:0] tgt_valid, tgt_ready, tgt_rvalid;
  logic          tgt_we, rsp_valid, rsp_err, proto_err;
  logic [NT*32-1:0] tgt_rdata;
  logic [2:0]    outstanding;

  always #5 clk = ~clk;

  sauria_addr_router dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_we(req_we), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_tgt_valid(tgt_valid), .i_tgt_ready(tgt_ready), .o_tgt_addr(tgt_addr),
    .o_tgt_we(tgt_we), .o_tgt_wdata(tgt_wdata), .o_tgt_be(tgt_be),
    .i_tgt_rvalid(tgt_rvalid), .i_tgt_rdata(tgt_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_proto_err(proto_err), .o_outstanding(outstanding)
  );

  int n_vec = 0, n_err = 0;

  typedef struct { bit we; bit miss; int idx; } txn_t;
  txn_t        q[$];
  bit          m_rsp_valid, m_rsp_err, m_proto, last_acc;
  logic [31:0] m_rsp_rdata;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // First region in table order whose masked address equals its base.
  function automatic void decode(input logic [31:0] a, output bit miss, output int idx);
    miss = 1; idx = 0;
    for (int i = 0; i < NT; i++)
      if (miss && ((a & MASK[i]) == BASE[i])) begin miss = 0; idx = i; end
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] u = $urandom;
    if (r < 5)       return (u & 32'hFFF0_01FF) | (r * 32'h200);
    else if (r < 8)  return (u & 32'hFFF0_FFFF) | ((r - 4) << 16);
    else if (r == 8) return (u & 32'hFFF0_FFFF) | 32'h0005_0000;
    else             return u;
  endfunction

  task automatic idle();
    req_valid = 0; tgt_rvalid = '0;
    for (int i = 0; i < NT; i++) tgt_rdata[i*32 +: 32] = $urandom;
  endtask

  task automatic req(input logic [31:0] a, input bit we);
    req_valid = 1; req_addr = a; req_we = we; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  // Compare every output against the model, then advance model and DUT one cycle.
  task automatic cycle();
    bit miss; int idx; bit room; logic [NT-1:0] exp_mask;
    #1;
    decode(req_addr, miss, idx);
    room = q.size() < MO;
    chk("req_ready", req_ready, room && (miss || tgt_ready[idx]));
    chk("tgt_valid", tgt_valid, (req_valid && room && !miss) ? 8'(1 << idx) : 8'h0);
    if (!miss) chk("tgt_addr", tgt_addr, req_addr & ~MASK[idx]);
    chk("tgt_we", tgt_we, req_we);
    chk("tgt_wdata", tgt_wdata, req_wdata);
    chk("tgt_be", tgt_be, req_be);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
    chk("rsp_err", rsp_err, m_rsp_err);
    chk("proto_err", proto_err, m_proto);
    chk("outstanding", outstanding, q.size());
    last_acc = req_valid && room && (miss || tgt_ready[idx]);
    exp_mask = (q.size() > 0 && !q[0].miss) ? 8'(1 << q[0].idx) : 8'h0;
    if ((tgt_rvalid & ~exp_mask) != 0) m_proto = 1;
    m_rsp_valid = 0; m_rsp_err = 0; m_rsp_rdata = '0;
    if (q.size() > 0 && (q[0].miss || tgt_rvalid[q[0].idx])) begin
      m_rsp_valid = 1; m_rsp_err = q[0].miss;
      if (!q[0].miss && !q[0].we) m_rsp_rdata = tgt_rdata[q[0].idx*32 +: 32];
      void'(q.pop_front());
    end
    if (last_acc) q.push_back('{we: req_we, miss: miss, idx: idx});
    @(posedge clk); @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset with immediate checks.
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_tgt_valid", tgt_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    q.delete(); m_rsp_valid = 0; m_rsp_err = 0; m_rsp_rdata = '0; m_proto = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && q.size() > 0; k++) begin
      idle();
      if (!q[0].miss) tgt_rvalid[q[0].idx] = 1;
      cycle();
    end
    idle(); #1 chk("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    logic [31:0] t4_addr [5];
    logic [3:0]  errs;
    int          nrsp;
    bit          pending;
    t4_addr = '{32'h0001_0000, 32'h0002_0000, 32'h0005_0000, 32'h0003_0000, 32'h0000_0200};

    idle(); tgt_ready = '1;
    req(32'h0001_0040, 1);
    do_reset();

    // Write to SRAMA, response one cycle after target rvalid.
    tgt_ready = '1; req(32'h0001_0040, 1);
    #1 chk("t1_valid", tgt_valid, 8'h20); chk("t1_addr", tgt_addr, 32'h40); chk("t1_ready", req_ready, 1);
    cycle();
    idle(); tgt_rvalid = 8'h20; cycle();
    idle(); #1 chk("t1_rsp", {rsp_valid, rsp_err}, 2'b10); chk("t1_rdata", rsp_rdata, 0);
    cycle();

    // Read from WEI, data returned after a delay.
    req(32'h0000_0604, 0);
    #1 chk("t2_valid", tgt_valid, 8'h08); chk("t2_addr", tgt_addr, 32'h4);
    cycle();
    idle(); cycle(); cycle();
    idle(); tgt_rvalid = 8'h08; tgt_rdata[3*32 +: 32] = 32'hDEAD_BEEF; cycle();
    idle(); #1 chk("t2_rsp", rsp_valid, 1); chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
    cycle();

    // Unmapped read: error response one cycle after reaching head.
    req(32'h0005_0000, 0);
    #1 chk("t3_valid", tgt_valid, 0); chk("t3_ready", req_ready, 1);
    cycle();
    idle(); #1 chk("t3_early", rsp_valid, 0);
    cycle();
    idle(); #1 chk("t3_rsp", {rsp_valid, rsp_err}, 2'b11); chk("t3_rdata", rsp_rdata, 0);
    chk("t3_proto", proto_err, 0);
    cycle();

    // Fill to MAX_OUT, then release responses in order.
    for (int i = 0; i < 4; i++) begin idle(); req(t4_addr[i], 0); cycle(); end
    idle(); req(t4_addr[4], 0);
    #1 chk("t4_full_ready", req_ready, 0); chk("t4_outstanding", outstanding, 4);
    cycle();
    pending = 1; nrsp = 0; errs = '0;
    for (int k = 0; k < 12; k++) begin
      idle();
      if (pending) req(t4_addr[4], 0);
      if (q.size() > 0 && !q[0].miss) tgt_rvalid[q[0].idx] = 1;
      #1;
      if (rsp_valid) begin
        if (nrsp < 4) errs[3 - nrsp] = rsp_err;
        nrsp++;
      end
      cycle();
      if (last_acc) pending = 0;
    end
    chk("t4_5th_accepted", pending, 0);
    chk("t4_rsp_count", nrsp >= 4, 1);
    chk("t4_err_order", errs, 4'b0010);
    drain();

    // Out-of-order rvalid sets sticky protocol error and is dropped.
    idle(); req(32'h0002_0000, 0); cycle();
    idle(); req(32'h0003_0000, 0); cycle();
    idle(); tgt_rvalid = 8'h80; cycle();
    idle(); #1 chk("t5_proto", proto_err, 1); chk("t5_no_rsp", rsp_valid, 0);
    tgt_rvalid = 8'hC0; tgt_rdata[6*32 +: 32] = 32'h1234_5678; cycle();
    idle(); #1 chk("t5_rsp6", rsp_valid, 1); chk("t5_rdata6", rsp_rdata, 32'h1234_5678);
    chk("t5_out", outstanding, 1);
    tgt_rvalid = 8'h80; tgt_rdata[7*32 +: 32] = 32'hCAFE_F00D; cycle();
    idle(); #1 chk("t5_rsp7", rsp_valid, 1); chk("t5_rdata7", rsp_rdata, 32'hCAFE_F00D);
    chk("t5_sticky", proto_err, 1);
    cycle();
    do_reset();

    // Randomized traffic with only legal responses.
    for (int c = 0; c < 3000; c++) begin
      idle();
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr = rand_addr(); req_we = 1'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
      tgt_ready = NT'($urandom | $urandom);
      if (q.size() > 0 && !q[0].miss && $urandom_range(0, 2) != 0) tgt_rvalid[q[0].idx] = 1;
      cycle();
    end
    drain();

    // Reset with outstanding work, then a late rvalid on an empty FIFO.
    tgt_ready = '1;
    for (int i = 0; i < 3; i++) begin idle(); req(t4_addr[i % 2], 0); cycle(); end
    idle(); req(32'h0001_0000, 0);
    #1 chk("t6_pre_out", outstanding, 3);
    do_reset();
    idle(); tgt_rvalid = 8'h20; cycle();
    idle(); #1 chk("t6_late_proto", proto_err, 1); chk("t6_no_rsp", rsp_valid, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
